// File: rtl/lsu_mem_handshake_if.sv
// Signal bundle between the LSU, the core's execute/memory path and the data memory port.
// slave = the LSU itself, master = whatever drives the core and memory sides.
interface lsu_mem_handshake_if #(
  parameter int ADDRESS    = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int MASK_W = DATA_WIDTH / 8;

  logic                  load;
  logic                  store;
  logic [2:0]            funct3;
  logic [ADDRESS-1:0]    alu_res_in;
  logic [DATA_WIDTH-1:0] store_data_in;
  logic                  stall;
  logic                  done;
  logic [DATA_WIDTH-1:0] load_data_out;
  logic                  err;
  logic                  data_mem_request;
  logic                  data_mem_we_re;
  logic [MASK_W-1:0]     data_mem_mask;
  logic [ADDRESS-1:0]    DM_address_out;
  logic [DATA_WIDTH-1:0] DM_store_data_out;
  logic [DATA_WIDTH-1:0] DM_load_data_in;
  logic                  DM_valid;

  modport slave (
    input  load, store, funct3, alu_res_in, store_data_in, DM_load_data_in, DM_valid,
    output stall, done, load_data_out, err, data_mem_request, data_mem_we_re,
           data_mem_mask, DM_address_out, DM_store_data_out
  );

  modport master (
    output load, store, funct3, alu_res_in, store_data_in, DM_load_data_in, DM_valid,
    input  stall, done, load_data_out, err, data_mem_request, data_mem_we_re,
           data_mem_mask, DM_address_out, DM_store_data_out
  );
endinterface

// File: rtl/lsu_mem_handshake.sv
// Multi-cycle load/store unit: IDLE -> REQ -> RESP handshake with byte lanes, load extension and timeout.
// Define MISALIGN_TRAP_EN to trap misaligned H/W/D accesses instead of force-aligning them.
module lsu_mem_handshake #(
  parameter int ADDRESS        = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic               clk,
  input logic               rst,
  lsu_mem_handshake_if.slave io_bus
);
  localparam int MASK_W = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(MASK_W);
  localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam bit IS64   = (DATA_WIDTH == 64);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [ADDRESS-1:0]    r_addr;
  logic [2:0]            r_funct3;
  logic [DATA_WIDTH-1:0] r_storeData;
  logic                  r_we;
  logic [CNT_W-1:0]      r_count;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_loadData;

  logic                  w_start;
  logic                  w_both;
  logic                  w_legalF3;
  logic                  w_misalign;
  logic                  w_reject;
  logic                  w_timeout;
  logic                  w_stall;
  logic                  w_request;
  logic [1:0]            w_size;
  logic [OFF_W-1:0]      w_off;
  logic [MASK_W-1:0]     w_mask;
  logic [DATA_WIDTH-1:0] w_storeRep;
  logic [DATA_WIDTH-1:0] w_lane;
  logic [DATA_WIDTH-1:0] w_loadExt;

  assign w_start   = rst && (io_bus.load ^ io_bus.store);
  assign w_both    = rst && io_bus.load && io_bus.store;
  assign w_timeout = (r_count == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_legalF3 = 1'b0;
    if (io_bus.load) begin
      case (io_bus.funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_legalF3 = 1'b1;
        3'b011, 3'b110:                         w_legalF3 = IS64;
        default:                                w_legalF3 = 1'b0;
      endcase
    end else begin
      case (io_bus.funct3)
        3'b000, 3'b001, 3'b010: w_legalF3 = 1'b1;
        3'b011:                 w_legalF3 = IS64;
        default:                w_legalF3 = 1'b0;
      endcase
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic [OFF_W-1:0] w_inOff;
  assign w_inOff = io_bus.alu_res_in[OFF_W-1:0];

  always_comb begin
    w_misalign = 1'b0;
    case (io_bus.funct3[1:0])
      2'b01:   w_misalign = w_inOff[0];
      2'b10:   w_misalign = |w_inOff[1:0];
      2'b11:   w_misalign = |w_inOff;
      default: w_misalign = 1'b0;
    endcase
  end
`else
  assign w_misalign = 1'b0;
`endif

  assign w_reject = w_both || (w_start && (!w_legalF3 || w_misalign));

  // Offset bits below the access size are dropped, giving natural alignment when not trapped.
  assign w_size = r_funct3[1:0];
  always_comb begin
    w_off = r_addr[OFF_W-1:0];
    case (w_size)
      2'b01:   w_off[0]   = 1'b0;
      2'b10:   w_off[1:0] = 2'b00;
      2'b11:   w_off      = '0;
      default: ;
    endcase
  end

  always_comb begin
    w_mask     = '1;
    w_storeRep = r_storeData;
    case (w_size)
      2'b00: begin
        w_mask     = MASK_W'(1) << w_off;
        w_storeRep = {MASK_W{r_storeData[7:0]}};
      end
      2'b01: begin
        w_mask     = MASK_W'(3) << w_off;
        w_storeRep = {(MASK_W / 2){r_storeData[15:0]}};
      end
      2'b10: begin
        w_mask     = MASK_W'(4'hF) << w_off;
        w_storeRep = {(MASK_W / 4){r_storeData[31:0]}};
      end
      default: ;
    endcase
  end

  assign w_lane = io_bus.DM_load_data_in >> {w_off, 3'b000};

  always_comb begin
    w_loadExt = w_lane;
    case (r_funct3)
      3'b000:  w_loadExt = DATA_WIDTH'($signed(w_lane[7:0]));
      3'b001:  w_loadExt = DATA_WIDTH'($signed(w_lane[15:0]));
      3'b010:  w_loadExt = DATA_WIDTH'($signed(w_lane[31:0]));
      3'b100:  w_loadExt = DATA_WIDTH'(w_lane[7:0]);
      3'b101:  w_loadExt = DATA_WIDTH'(w_lane[15:0]);
      3'b110:  w_loadExt = DATA_WIDTH'(w_lane[31:0]);
      default: w_loadExt = w_lane;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_stall     = 1'b0;
    w_request   = 1'b0;
    case (r_state)
      IDLE: begin
        w_stall = w_start;
        if (w_reject)     w_nextState = RESP;
        else if (w_start) w_nextState = REQ;
      end
      REQ: begin
        w_stall   = 1'b1;
        w_request = 1'b1;
        if (io_bus.DM_valid || w_timeout) w_nextState = RESP;
      end
      RESP:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // DM_valid is checked before the timeout so a response arriving on the last cycle still succeeds.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_addr      <= '0;
      r_funct3    <= '0;
      r_storeData <= '0;
      r_we        <= 1'b0;
      r_count     <= '0;
      r_err       <= 1'b0;
      r_loadData  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start || w_reject) begin
            r_addr      <= io_bus.alu_res_in;
            r_funct3    <= io_bus.funct3;
            r_storeData <= io_bus.store_data_in;
            r_we        <= io_bus.store;
            r_count     <= '0;
            r_err       <= w_reject;
            if (w_reject) r_loadData <= '0;
          end
        end
        REQ: begin
          if (io_bus.DM_valid) begin
            r_err <= 1'b0;
            if (!r_we) r_loadData <= w_loadExt;
          end else if (w_timeout) begin
            r_err      <= 1'b1;
            r_loadData <= '0;
          end else begin
            r_count <= r_count + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign io_bus.stall             = w_stall;
  assign io_bus.done              = (r_state == RESP);
  assign io_bus.err               = (r_state == RESP) && r_err;
  assign io_bus.load_data_out     = r_loadData;
  assign io_bus.data_mem_request  = w_request;
  assign io_bus.data_mem_we_re    = w_request && r_we;
  assign io_bus.data_mem_mask     = w_request ? w_mask : '0;
  assign io_bus.DM_address_out    = w_request ? {r_addr[ADDRESS-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign io_bus.DM_store_data_out = w_request ? w_storeRep : '0;

endmodule

// File: tb/tb_lsu_mem_handshake.sv
// Scoreboard bench for lsu_mem_handshake (32-bit data, 4-cycle timeout); follows MISALIGN_TRAP_EN if defined.
module tb_lsu_mem_handshake;
  localparam int TIMEOUT = 4;

  typedef struct {
    logic [3:0]  mask;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] ldata;
    logic        we;
    logic        err;
    bit          req;
    bit          chkLoad;
    int          latency;
    int          reqCycles;
  } exp_t;

  logic clk;
  logic rst;
  int   checkCount = 0;
  int   passCount  = 0;
  exp_t expQ[$];

  lsu_mem_handshake_if #(.ADDRESS(32), .DATA_WIDTH(32)) bus ();

  lsu_mem_handshake #(.ADDRESS(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk   (clk),
    .rst   (rst),
    .io_bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  // Reference built straight from the access rules: byte counts, modulo alignment, per-bit extension.
  function automatic exp_t modelAccess(input bit ld, input bit st, input logic [2:0] f3,
                                       input logic [31:0] addr, input logic [31:0] sdata,
                                       input logic [31:0] mem, input int validAt);
    exp_t        e;
    int          nBytes;
    int          off;
    bit          legal;
    logic [31:0] lane;
    e = '{default: 0};
    nBytes = 1 << f3[1:0];
    legal  = (ld != st) && (nBytes <= 4) && !(ld && f3 == 3'b110) && !(st && f3[2]);
    off    = int'(addr[1:0]);
`ifdef MISALIGN_TRAP_EN
    if (legal && (off % nBytes) != 0) legal = 1'b0;
`else
    off = off - (off % nBytes);
`endif
    if (!legal) begin
      e.err = 1'b1; e.chkLoad = 1'b1; e.latency = 1;
      return e;
    end
    e.req  = 1'b1;
    e.we   = st;
    e.addr = {addr[31:2], 2'b00};
    e.mask = 4'(((1 << nBytes) - 1) << off);
    for (int i = 0; i < 4; i++) e.sdata[i*8 +: 8] = sdata[(i % nBytes)*8 +: 8];
    if (validAt < 0 || validAt >= TIMEOUT) begin
      e.err = 1'b1; e.chkLoad = ld; e.latency = TIMEOUT + 1; e.reqCycles = TIMEOUT;
      return e;
    end
    e.latency   = validAt + 2;
    e.reqCycles = validAt + 1;
    if (ld) begin
      e.chkLoad = 1'b1;
      lane = mem >> (off * 8);
      for (int b = 0; b < 32; b++)
        e.ldata[b] = (b < nBytes * 8) ? lane[b] : (f3[2] ? 1'b0 : lane[nBytes*8 - 1]);
    end
    return e;
  endfunction

  // Drives one access from IDLE and returns one cycle after its done pulse.
  task automatic applyStimulus(input string tag, input bit ld, input bit st, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] sdata,
                               input logic [31:0] mem, input int validAt);
    exp_t e;
    int   cycles;
    int   reqSeen;
    expQ.push_back(modelAccess(ld, st, f3, addr, sdata, mem, validAt));
    bus.load = ld; bus.store = st; bus.funct3 = f3;
    bus.alu_res_in = addr; bus.store_data_in = sdata; bus.DM_valid = 1'b0;
    #1;
    checkOutput({tag, ".stallStart"}, bus.stall, ld ^ st);
    @(posedge clk); #1;
    bus.load = 1'b0; bus.store = 1'b0;
    bus.alu_res_in = $urandom; bus.store_data_in = $urandom;
    cycles = 1; reqSeen = 0;
    while (!bus.done && cycles < 20) begin
      if (bus.data_mem_request) begin
        if (reqSeen == 0) begin
          checkOutput({tag, ".mask"},  bus.data_mem_mask,     expQ[0].mask);
          checkOutput({tag, ".addr"},  bus.DM_address_out,    expQ[0].addr);
          checkOutput({tag, ".we"},    bus.data_mem_we_re,    expQ[0].we);
          checkOutput({tag, ".stall"}, bus.stall,             1'b1);
          if (expQ[0].we) checkOutput({tag, ".sdata"}, bus.DM_store_data_out, expQ[0].sdata);
        end
        reqSeen++;
        if (reqSeen - 1 == validAt) begin
          bus.DM_valid = 1'b1;
          bus.DM_load_data_in = mem;
        end
      end
      @(posedge clk); #1;
      bus.DM_valid = 1'b0;
      bus.DM_load_data_in = $urandom;
      cycles++;
    end
    checkOutput({tag, ".done"}, bus.done, 1'b1);
    checkOutput({tag, ".sbSize"}, expQ.size(), 1);
    e = expQ.pop_front();
    checkOutput({tag, ".latency"},   cycles,  e.latency);
    checkOutput({tag, ".reqCycles"}, reqSeen, e.reqCycles);
    checkOutput({tag, ".err"},       bus.err, e.err);
    checkOutput({tag, ".doneReq"},   bus.data_mem_request, 1'b0);
    checkOutput({tag, ".doneStall"}, bus.stall, 1'b0);
    if (e.chkLoad) checkOutput({tag, ".ldata"}, bus.load_data_out, e.ldata);
    @(posedge clk); #1;
    checkOutput({tag, ".donePulse"}, bus.done, 1'b0);
    if (e.chkLoad) checkOutput({tag, ".ldataHold"}, bus.load_data_out, e.ldata);
  endtask

  initial begin
    logic [2:0] ldF3[5];
    logic [2:0] stF3[3];
    bit         isLd;
    ldF3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    stF3 = '{3'b000, 3'b001, 3'b010};

    rst = 1'b0;
    bus.load = 1'b0; bus.store = 1'b0; bus.funct3 = '0; bus.alu_res_in = '0;
    bus.store_data_in = '0; bus.DM_load_data_in = '0; bus.DM_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.stall",   bus.stall,             1'b0);
    checkOutput("reset.done",    bus.done,              1'b0);
    checkOutput("reset.err",     bus.err,               1'b0);
    checkOutput("reset.request", bus.data_mem_request,  1'b0);
    checkOutput("reset.mask",    bus.data_mem_mask,     4'h0);
    checkOutput("reset.addr",    bus.DM_address_out,    32'h0);
    checkOutput("reset.sdata",   bus.DM_store_data_out, 32'h0);
    checkOutput("reset.ldata",   bus.load_data_out,     32'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    applyStimulus("sw",       1'b0, 1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0,        0);
    applyStimulus("lb",       1'b1, 1'b0, 3'b000, 32'h203, 32'h0,        32'h80112233, 0);
    applyStimulus("lbu",      1'b1, 1'b0, 3'b100, 32'h203, 32'h0,        32'h80112233, 0);
    applyStimulus("sh",       1'b0, 1'b1, 3'b001, 32'h12,  32'h0000ABCD, 32'h0,        0);
    applyStimulus("lh",       1'b1, 1'b0, 3'b001, 32'h2,   32'h0,        32'h80017FFF, 1);
    applyStimulus("lhu",      1'b1, 1'b0, 3'b101, 32'h2,   32'h0,        32'h80017FFF, 0);
    applyStimulus("lwSlow",   1'b1, 1'b0, 3'b010, 32'h40,  32'h0,        32'h12345678, 2);
    applyStimulus("sb",       1'b0, 1'b1, 3'b000, 32'h21,  32'h0000005A, 32'h0,        0);
    applyStimulus("lbPos",    1'b1, 1'b0, 3'b000, 32'h1,   32'h0,        32'h00007F00, 0);
    applyStimulus("lwTimeout",1'b1, 1'b0, 3'b010, 32'h80,  32'h0,        32'h0,       -1);
    applyStimulus("lwLastVld",1'b1, 1'b0, 3'b010, 32'h84,  32'h0,        32'hA5A5C3C3, TIMEOUT - 1);
    applyStimulus("lwMisal",  1'b1, 1'b0, 3'b010, 32'h101, 32'h0,        32'hCAFEF00D, 0);
    applyStimulus("shMisal",  1'b0, 1'b1, 3'b001, 32'h33,  32'h00001234, 32'h0,        0);
    applyStimulus("lwu32",    1'b1, 1'b0, 3'b110, 32'h100, 32'h0,        32'h0,        0);
    applyStimulus("ld32",     1'b1, 1'b0, 3'b011, 32'h100, 32'h0,        32'h0,        0);
    applyStimulus("sd32",     1'b0, 1'b1, 3'b011, 32'h100, 32'h0,        32'h0,        0);
    applyStimulus("ldAndSt",  1'b1, 1'b1, 3'b010, 32'h100, 32'h0,        32'h0,        0);
    applyStimulus("lbAfter",  1'b1, 1'b0, 3'b000, 32'h0,   32'h0,        32'h000000FE, 0);

    for (int n = 0; n < 20; n++) begin
      isLd = 1'($urandom_range(0, 1));
      applyStimulus("rand", isLd, !isLd,
                    isLd ? ldF3[$urandom_range(0, 4)] : stF3[$urandom_range(0, 2)],
                    $urandom, $urandom, $urandom, int'($urandom_range(0, 2)));
    end

    // Reset while a request is outstanding must abandon it and ignore a late response.
    bus.load = 1'b1; bus.funct3 = 3'b010; bus.alu_res_in = 32'h300;
    @(posedge clk); #1;
    bus.load = 1'b0;
    checkOutput("rstMid.reqBefore", bus.data_mem_request, 1'b1);
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("rstMid.request", bus.data_mem_request, 1'b0);
    checkOutput("rstMid.stall",   bus.stall,            1'b0);
    checkOutput("rstMid.done",    bus.done,             1'b0);
    rst = 1'b1;
    bus.DM_valid = 1'b1; bus.DM_load_data_in = 32'h11223344;
    @(posedge clk); #1;
    bus.DM_valid = 1'b0;
    checkOutput("rstMid.lateDone",    bus.done,             1'b0);
    checkOutput("rstMid.lateRequest", bus.data_mem_request, 1'b0);
    @(posedge clk); #1;
    checkOutput("rstMid.idleDone", bus.done,          1'b0);
    checkOutput("rstMid.ldata",    bus.load_data_out, 32'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
